bambu_host_ctrl: RTL

Synthesizable host-side controller for a Bambu-generated `main` accelerator: it replaces the simulation-only testbench sequencing with RTL. It takes commands on a valid/ready stream and executes each one:
- writes go to the accelerator's slave RAM port (`S_*` / `Sout_*`);
- reads come back from the same port;
- a run command pulses `start_port` and measures cycles until `done_port`.

It sits between a host link (UART/JTAG bridge) and `main`, on channel 0 of the slave port.

---
 rtl/bambu_host_pkg.sv | 29 ++
 rtl/bambu_sat_counter.sv | 29 ++
 rtl/bambu_host_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bambu_host_pkg.sv
// Shared types for the Bambu host-side controller:
// command ops, response status, FSM state encoding and counter width.
package bambu_host_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_RUN   = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_BAD_OP  = 2'd2
   } status_e;

   typedef logic [2:0] state_t;

   localparam state_t FSM_IDLE      = 3'd0;
   localparam state_t FSM_MEM_REQ   = 3'd1;
   localparam state_t FSM_MEM_WAIT  = 3'd2;
   localparam state_t FSM_RUN_START = 3'd3;
   localparam state_t FSM_RUN_WAIT  = 3'd4;
   localparam state_t FSM_RESP      = 3'd5;

endpackage

// File: rtl/bambu_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// `value` is the count including the current cycle (q+1, saturated).
module bambu_sat_counter
   import bambu_host_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] value
);

   logic [W-1:0] q;

   assign value = (&q) ? q : q + W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (enable) begin
         q <= value;
      end
   end

endmodule

// File: rtl/bambu_host_ctrl.sv
// Host-side command controller for a Bambu `main` accelerator (slave port ch 0).
// Optional wait timeout enabled by defining BAMBU_HOST_CTRL_TIMEOUT_EN.
module bambu_host_ctrl
   import bambu_host_pkg::*;
#(
   parameter int          CHANNELS       = 2,
   parameter int          BITSIZE_ADDR   = 7,
   parameter int          BITSIZE_DATA   = 8,
   parameter int          BITSIZE_SIZE   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [1:0]                       cmd_op,
   input  logic [BITSIZE_ADDR-1:0]          cmd_addr,
   input  logic [BITSIZE_DATA-1:0]          cmd_wdata,
   input  logic [BITSIZE_SIZE-1:0]          cmd_size,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [31:0]                      rsp_data,
   output logic [1:0]                       rsp_status,
   output logic                             spurious_done,
   output logic                             start_port,
   input  logic                             done_port,
   output logic [CHANNELS-1:0]              S_oe_ram,
   output logic [CHANNELS-1:0]              S_we_ram,
   output logic [CHANNELS*BITSIZE_ADDR-1:0] S_addr_ram,
   output logic [CHANNELS*BITSIZE_DATA-1:0] S_Wdata_ram,
   output logic [CHANNELS*BITSIZE_SIZE-1:0] S_data_ram_size,
   input  logic [CHANNELS*BITSIZE_DATA-1:0] Sout_Rdata_ram,
   input  logic [CHANNELS-1:0]              Sout_DataRdy
);

   state_t                  state_q;
   state_t                  state_d;
   op_e                     op_q;
   logic [BITSIZE_ADDR-1:0] addr_q;
   logic [BITSIZE_DATA-1:0] wdata_q;
   logic [BITSIZE_SIZE-1:0] size_q;
   logic [CNT_W-1:0]        data_q;
   status_e                 status_q;
   logic                    armed_q;
   logic                    spur_q;

   logic                    accept;
   logic                    ld;
   logic [CNT_W-1:0]        ld_data;
   status_e                 ld_status;
   logic [CNT_W-1:0]        cyc_cnt;
   logic [CNT_W-1:0]        wait_cnt;
   logic                    tmo_hit;
   logic                    in_run;

   // armed_q keeps cmd_ready low while reset is held
   assign accept = (state_q == FSM_IDLE) && armed_q && cmd_valid;
   assign in_run = (state_q == FSM_RUN_START) ||
                   (state_q == FSM_RUN_WAIT);

   bambu_sat_counter #(.W(CNT_W)) u_cyc_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (state_q == FSM_RUN_START),
      .enable (state_q == FSM_RUN_WAIT),
      .value  (cyc_cnt)
   );

`ifdef BAMBU_HOST_CTRL_TIMEOUT_EN
   logic start_wait;
   logic in_wait;

   assign start_wait = (state_q == FSM_MEM_REQ) ||
                       (state_q == FSM_RUN_START);
   assign in_wait    = (state_q == FSM_MEM_WAIT) ||
                       (state_q == FSM_RUN_WAIT);

   bambu_sat_counter #(.W(CNT_W)) u_wait_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (start_wait),
      .enable (in_wait),
      .value  (wait_cnt)
   );

   assign tmo_hit = wait_cnt >= CNT_W'(TIMEOUT_CYCLES);
`else
   logic unused_tmo;

   assign wait_cnt   = '0;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      ld        = 1'b0;
      ld_data   = '0;
      ld_status = ST_OK;
      case (state_q)
         FSM_IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  (cmd_op == OP_WRITE),
                  (cmd_op == OP_READ): state_d = FSM_MEM_REQ;
                  (cmd_op == OP_RUN):  state_d = FSM_RUN_START;
                  default: begin
                     state_d   = FSM_RESP;
                     ld        = 1'b1;
                     ld_status = ST_BAD_OP;
                  end
               endcase
            end
         end
         FSM_MEM_REQ: state_d = FSM_MEM_WAIT;
         FSM_MEM_WAIT: begin
            if (Sout_DataRdy[0]) begin
               state_d = FSM_RESP;
               ld      = 1'b1;
               if (op_q == OP_READ) begin
                  ld_data = CNT_W'(Sout_Rdata_ram[BITSIZE_DATA-1:0]);
               end
            end else if (tmo_hit) begin
               state_d   = FSM_RESP;
               ld        = 1'b1;
               ld_data   = wait_cnt;
               ld_status = ST_TIMEOUT;
            end
         end
         FSM_RUN_START: begin
            // done coinciding with the start pulse reports zero cycles
            if (done_port) begin
               state_d = FSM_RESP;
               ld      = 1'b1;
            end else begin
               state_d = FSM_RUN_WAIT;
            end
         end
         FSM_RUN_WAIT: begin
            if (done_port) begin
               state_d = FSM_RESP;
               ld      = 1'b1;
               ld_data = cyc_cnt;
            end else if (tmo_hit) begin
               state_d   = FSM_RESP;
               ld        = 1'b1;
               ld_data   = wait_cnt;
               ld_status = ST_TIMEOUT;
            end
         end
         FSM_RESP: begin
            if (rsp_ready) state_d = FSM_IDLE;
         end
         default: state_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= FSM_IDLE;
         armed_q  <= 1'b0;
         spur_q   <= 1'b0;
         op_q     <= OP_WRITE;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         data_q   <= '0;
         status_q <= ST_OK;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         if (done_port && !in_run) spur_q <= 1'b1;
         if (accept) begin
            op_q    <= op_e'(cmd_op);
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            size_q  <= cmd_size;
         end
         if (ld) begin
            data_q   <= ld_data;
            status_q <= ld_status;
         end
      end
   end

   always_comb begin
      S_oe_ram        = '0;
      S_we_ram        = '0;
      S_addr_ram      = '0;
      S_Wdata_ram     = '0;
      S_data_ram_size = '0;
      if (state_q == FSM_MEM_REQ) begin
         S_addr_ram[BITSIZE_ADDR-1:0]      = addr_q;
         S_data_ram_size[BITSIZE_SIZE-1:0] = size_q;
         S_we_ram[0] = (op_q == OP_WRITE);
         S_oe_ram[0] = (op_q == OP_READ);
         if (op_q == OP_WRITE) begin
            S_Wdata_ram[BITSIZE_DATA-1:0] = wdata_q;
         end
      end
   end

   // channel 1 of the slave port is never used
   logic unused_ch1;
   assign unused_ch1 = ^{Sout_DataRdy[CHANNELS-1:1],
      Sout_Rdata_ram[CHANNELS*BITSIZE_DATA-1:BITSIZE_DATA]};

   assign cmd_ready     = (state_q == FSM_IDLE) && armed_q;
   assign rsp_valid     = (state_q == FSM_RESP);
   assign rsp_data      = 32'(data_q);
   assign rsp_status    = status_q;
   assign start_port    = (state_q == FSM_RUN_START);
   assign spurious_done = spur_q;

endmodule
